// File: rtl/truth_table_sweep_v.sv
// Sweeps a 3-input gate over all eight input indices and captures its truth table.
// Optional TRUTH_SWEEP_PARITY_EN adds o_tt_par, the XOR of the captured table.
module truth_table_sweep_v (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   input  logic       i_all_codes,
   input  logic [1:0] i_code_sel,
   output logic       o_a,
   output logic       o_b,
   output logic       o_c,
   output logic [1:0] o_code,
   input  logic       i_f,
   output logic [7:0] o_tt,
   output logic [1:0] o_tt_code,
   output logic       o_tt_valid,
   input  logic       i_tt_ready,
`ifdef TRUTH_SWEEP_PARITY_EN
   output logic       o_tt_par,
`endif
   output logic       o_busy,
   output logic       o_done
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SWEEP   = 2'd1,
      PRESENT = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t     state_q;
   logic [2:0] idx_q;
   logic [1:0] code_q;
   logic       all_q;
   logic [7:0] tt_q;
   logic [7:0] tt_d;
   logic [1:0] tt_code_q;
   logic       valid_q;
   logic       busy_q;
   logic       done_q;
   logic       last_idx;
   logic       more_codes;
`ifdef TRUTH_SWEEP_PARITY_EN
   logic       par_q;
`endif

   // Table with the current gate result merged in at the current index.
   always_comb begin
      tt_d        = tt_q;
      tt_d[idx_q] = i_f;
   end

   assign last_idx   = (idx_q == 3'd7);
   assign more_codes = all_q && (code_q != 2'd3);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         idx_q     <= 3'd0;
         code_q    <= 2'd0;
         all_q     <= 1'b0;
         tt_q      <= 8'h00;
         tt_code_q <= 2'd0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef TRUTH_SWEEP_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (i_start) begin
                  all_q   <= i_all_codes;
                  code_q  <= i_all_codes ? 2'd0 : i_code_sel;
                  idx_q   <= 3'd0;
                  busy_q  <= 1'b1;
                  state_q <= SWEEP;
               end
            end
            SWEEP: begin
               tt_q <= tt_d;
               if (last_idx) begin
                  idx_q     <= 3'd0;
                  tt_code_q <= code_q;
                  valid_q   <= 1'b1;
`ifdef TRUTH_SWEEP_PARITY_EN
                  par_q     <= ^tt_d;
`endif
                  state_q   <= PRESENT;
               end else begin
                  idx_q <= idx_q + 3'd1;
               end
            end
            PRESENT: begin
               if (i_tt_ready) begin
                  valid_q <= 1'b0;
                  if (more_codes) begin
                     code_q  <= code_q + 2'd1;
                     state_q <= SWEEP;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // idx_q only leaves zero while sweeping, so this is the stimulus directly.
   assign {o_a, o_b, o_c} = idx_q;
   assign o_code     = code_q;
   assign o_tt       = tt_q;
   assign o_tt_code  = tt_code_q;
   assign o_tt_valid = valid_q;
   assign o_busy     = busy_q;
   assign o_done     = done_q;
`ifdef TRUTH_SWEEP_PARITY_EN
   assign o_tt_par   = par_q;
`endif

endmodule

// File: doc/truth_table_sweep_v.md
TRUTH_TABLE_SWEEP_V -- requirements
Module: truth_table_sweep_v

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: i_clk (rising edge) and i_rst_n (0 = reset, asserted at any time, released synchronously by the system).
REQ-002 Ports SHALL be:
  i_clk  in  1  clock
  i_rst_n  in  1  async active-low reset
  i_start  in  1  start-sweep pulse
  i_all_codes  in  1  1 = sweep codes 0..3; 0 = sweep i_code_sel only (sampled at start)
  i_code_sel  in  2  single code to sweep (sampled at start)
  o_a, o_b, o_c  out  1 each  gate stimulus; {o_a,o_b,o_c} = index, o_a MSB
  o_code  out  2  gate function select
  i_f  in  1  gate result, combinational from o_a/o_b/o_c/o_code
  o_tt  out  8  captured truth table; bit n = i_f at index n
  o_tt_code  out  2  code that o_tt belongs to
  o_tt_valid  out  1  o_tt/o_tt_code valid
  i_tt_ready  in  1  consumer accepts o_tt
  o_busy  out  1  sweep in progress (state != IDLE)
  o_done  out  1  one-cycle pulse, whole run complete

Function
REQ-003 FSM states SHALL be IDLE, SWEEP, PRESENT, DONE.
REQ-004 IDLE: i_start=1 latches i_all_codes, and the start code (0 if all-codes, else i_code_sel); next state SWEEP, index=0.
REQ-005 All stimulus outputs (o_a, o_b, o_c, o_code) SHALL be registered; in SWEEP they present current index/code, in other states index outputs = 0 and o_code holds last value.
REQ-006 SWEEP: each cycle o_tt[index] SHALL capture i_f; index increments by 1; at index 7 capture occurs, index wraps to 0, next state PRESENT.
REQ-007 Latency: i_start at cycle 0 -> index 0 driven cycle 1 -> index 7 cycle 8 -> o_tt_valid=1 cycle 9.
REQ-008 PRESENT: o_tt_valid=1; o_tt and o_tt_code SHALL stay stable while i_tt_ready=0 (unbounded backpressure).
REQ-009 PRESENT with i_tt_ready=1 (handshake): if all-codes and code<3, code+1 and next SWEEP; otherwise next DONE.
REQ-010 DONE: o_done=1 for exactly one cycle; next IDLE.
REQ-011 i_start SHALL be ignored in every state except IDLE, including the cycle a handshake occurs.
REQ-012 With i_tt_ready tied 1, an all-codes run SHALL take 36 cycles from start to last handshake; o_done asserts the following cycle.
REQ-013 o_tt SHALL be fully overwritten each sweep; no bits carry over between codes.

Reset
REQ-014 i_rst_n=0 SHALL immediately force: state IDLE, index 0, o_a=o_b=o_c=0, o_code=0, o_tt=0x00, o_tt_code=0, o_tt_valid=0, o_busy=0, o_done=0.
REQ-015 Reset mid-sweep or mid-PRESENT SHALL abandon the run with no handshake and no o_done; the first i_start after reset release begins a fresh run.

Configuration
REQ-016 Macro TRUTH_SWEEP_PARITY_EN defined: extra output o_tt_par (1 bit) SHALL equal XOR of o_tt bits, registered with o_tt, valid with o_tt_valid, reset 0.
REQ-017 Macro undefined: o_tt_par port and logic SHALL be absent; all other behaviour identical.

Verification (bench gate model: code0 XOR3, code1 NAND3, code2 NOR3, code3 XNOR3)
REQ-018 Reset, pulse i_start with i_all_codes=1, i_tt_ready=1 -> o_tt 0x96,0x7F,0x01,0x69 with o_tt_code 0..3, valid first at cycle 9, o_done one cycle after the 4th handshake.
REQ-019 i_all_codes=0, i_code_sel=2 -> single o_tt=0x01, o_tt_code=2, then o_done; o_code never leaves 2 during sweep.
REQ-020 i_tt_ready=0 for 5 cycles in PRESENT -> o_tt_valid and o_tt held unchanged for 5 cycles, next code starts only after ready=1.
REQ-021 i_start pulsed during SWEEP and in the handshake cycle -> no restart, results and timing identical to REQ-018.
REQ-022 i_rst_n=0 at index 4 of code 1 -> all outputs reset values same cycle, no o_done; new i_start yields 0x96 first.
REQ-023 With TRUTH_SWEEP_PARITY_EN: o_tt_par = 0,1,1,0 for codes 0..3 in the REQ-018 run.
